// File: rtl/life_pkg.sv
// Shared types and constants for the 8x8 Game-of-Life run controller.
package life_pkg;
    localparam int GRID_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAUSE = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } ctrl_state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        EXTINCT = 2'd1,
        STILL   = 2'd2,
        OSC2    = 2'd3
    } halt_cause_t;
endpackage

// File: rtl/life_tick_gen.sv
// Generation-rate divider: counts 0..TICK_DIV-1 while enabled and flags the terminal count.
module life_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end

    // A clear on the terminal cycle (pause/load) suppresses that commit.
    assign tick = enable && !clear && (count_reg == LAST);
endmodule

// File: rtl/life_run_ctrl.sv
// Run controller: holds the current generation, sequences load/run/pause/step,
// counts generations and halts on extinction, still life, period-2 or a limit.
module life_run_ctrl
    import life_pkg::*;
#(
    parameter int               TICK_DIV = 25_000_000,
    parameter int               GEN_W    = 16,
    parameter logic [GEN_W-1:0] MAX_GEN  = GEN_W'(1000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_load,
    input  logic              cmd_run,
    input  logic              cmd_pause,
    input  logic              cmd_step,
    input  logic [GRID_W-1:0] seed,
    input  logic [GRID_W-1:0] next_grid,
    output logic [GRID_W-1:0] cur_grid,
    output logic [GEN_W-1:0]  gen_count,
    output logic              evolve,
    output logic              running,
    output logic              halted,
    output logic [1:0]        halt_cause
);
    ctrl_state_t       state_reg;
    ctrl_state_t       state_next;
    halt_cause_t       halt_cause_reg;
    halt_cause_t       cause_next;
    logic [GRID_W-1:0] prev_grid_reg;
    logic              prev_valid_reg;

    logic              tick;
    logic              tick_clear;
    logic              pause_go;
    logic              step_go;
    logic              run_go;
    logic              commit;
    logic              halt_hit;
    logic [GEN_W:0]    gen_plus1;
    logic [GEN_W-1:0]  gen_sat_next;

    assign tick_clear = (state_reg != RUN) || cmd_load || cmd_pause;

    life_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (tick_clear),
        .enable (state_reg == RUN),
        .tick   (tick)
    );

    // Priority load > pause > step > run; only the winning command is considered.
    always_comb begin
        pause_go   = !cmd_load && cmd_pause && (state_reg == RUN);
        step_go    = !cmd_load && !cmd_pause && cmd_step && (state_reg == PAUSE);
        run_go     = !cmd_load && !cmd_pause && !cmd_step && cmd_run && (state_reg == PAUSE);
        commit     = step_go || (!cmd_load && !cmd_pause && (state_reg == RUN) && tick);

        gen_plus1    = {1'b0, gen_count} + 1'b1;
        gen_sat_next = (&gen_count) ? gen_count : gen_plus1[GEN_W-1:0];

        halt_hit   = 1'b1;
        cause_next = NONE;
        if (next_grid == '0) begin
            cause_next = EXTINCT;
        end else if (next_grid == cur_grid) begin
            cause_next = STILL;
        end else if (prev_valid_reg && (next_grid == prev_grid_reg)) begin
            cause_next = OSC2;
        end else if ((MAX_GEN != '0) && (gen_plus1 == {1'b0, MAX_GEN})) begin
            cause_next = NONE;
        end else begin
            halt_hit = 1'b0;
        end

        state_next = state_reg;
        if (cmd_load) begin
            state_next = PAUSE;
        end else if (pause_go) begin
            state_next = PAUSE;
        end else if (run_go) begin
            state_next = RUN;
        end else if (commit && halt_hit) begin
            state_next = HALT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            cur_grid       <= '0;
            prev_grid_reg  <= '0;
            prev_valid_reg <= 1'b0;
            gen_count      <= '0;
            halt_cause_reg <= NONE;
            evolve         <= 1'b0;
            running        <= 1'b0;
            halted         <= 1'b0;
        end else begin
            state_reg <= state_next;
            running   <= (state_next == RUN);
            halted    <= (state_next == HALT);
            evolve    <= commit;
            if (cmd_load) begin
                cur_grid       <= seed;
                gen_count      <= '0;
                prev_valid_reg <= 1'b0;
                halt_cause_reg <= NONE;
            end else if (commit) begin
                prev_grid_reg  <= cur_grid;
                cur_grid       <= next_grid;
                prev_valid_reg <= 1'b1;
                gen_count      <= gen_sat_next;
                if (halt_hit) begin
                    halt_cause_reg <= cause_next;
                end
            end
        end
    end

    assign halt_cause = halt_cause_reg;
endmodule

// File: tb/tb_life_run_ctrl.sv
// Scoreboard bench for life_run_ctrl with a behavioural 8x8 life datapath (dead border).
module tb_life_run_ctrl;
    import life_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_load, cmd_run, cmd_pause, cmd_step;
    logic [63:0] seed;
    logic [63:0] next_grid;
    logic [63:0] cur_grid;
    logic [15:0] gen_count;
    logic        evolve, running, halted;
    logic [1:0]  halt_cause;

    always #5 clk = ~clk;

    life_run_ctrl #(.TICK_DIV(4), .GEN_W(16), .MAX_GEN(16'd3)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_load   (cmd_load),
        .cmd_run    (cmd_run),
        .cmd_pause  (cmd_pause),
        .cmd_step   (cmd_step),
        .seed       (seed),
        .next_grid  (next_grid),
        .cur_grid   (cur_grid),
        .gen_count  (gen_count),
        .evolve     (evolve),
        .running    (running),
        .halted     (halted),
        .halt_cause (halt_cause)
    );

    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] n;
        int cnt, rr, cc;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            if (g[rr*8+cc]) cnt++;
                    end
                end
                n[r*8+c] = g[r*8+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    always_comb next_grid = life_next(cur_grid);

    typedef struct {
        logic [63:0] grid;
        logic [15:0] gen;
        logic        hlt;
        logic [1:0]  cause;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] g, input logic [15:0] n, input logic h, input logic [1:0] c);
        exp_t e;
        e.grid = g; e.gen = n; e.hlt = h; e.cause = c;
        sb_q.push_back(e);
    endtask

    // Monitor: every evolve pulse is one transaction checked against the queue head.
    always @(negedge clk) begin
        if (!reset && evolve) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_evolve: got cur_grid=%h gen=%0d expected no commit", cur_grid, gen_count);
            end else begin
                mon_e = sb_q.pop_front();
                $display("commit: cur_grid=%h gen=%0d halted=%0b cause=%0d", cur_grid, gen_count, halted, halt_cause);
                check("commit_grid",   cur_grid,   mon_e.grid);
                check("commit_gen",    64'(gen_count),  64'(mon_e.gen));
                check("commit_halted", 64'(halted),     64'(mon_e.hlt));
                check("commit_cause",  64'(halt_cause), 64'(mon_e.cause));
            end
        end
    end

    task automatic pulse(input int which);
        @(negedge clk);
        cmd_load  = (which == 0);
        cmd_run   = (which == 1);
        cmd_pause = (which == 2);
        cmd_step  = (which == 3);
        @(negedge clk);
        cmd_load = 1'b0; cmd_run = 1'b0; cmd_pause = 1'b0; cmd_step = 1'b0;
    endtask

    task automatic load_seed(input logic [63:0] s);
        seed = s;
        pulse(0);
        check("load_grid", cur_grid, s);
    endtask

    task automatic wait_halted(input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("halt_reached", 64'(halted), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cmd_load = 1'b0; cmd_run = 1'b0; cmd_pause = 1'b0; cmd_step = 1'b0;
        seed = '0;
        repeat (3) @(negedge clk);
        check("rst_grid",    cur_grid,   64'd0);
        check("rst_gen",     64'(gen_count), 64'd0);
        check("rst_flags",   64'({evolve, running, halted}), 64'd0);
        check("rst_cause",   64'(halt_cause), 64'd0);
        reset = 1'b0;

        // Step in IDLE is ignored
        pulse(3);
        @(negedge clk);
        check("idle_step_gen",  64'(gen_count), 64'd0);
        check("idle_step_grid", cur_grid, 64'd0);

        // Blinker: oscillates, second commit matches prev -> OSC2
        load_seed(64'h1C0000);
        push(64'h08080800, 16'd1, 1'b0, 2'(NONE));
        push(64'h001C0000, 16'd2, 1'b1, 2'(OSC2));
        pulse(1);
        check("run_running", 64'(running), 64'd1);
        repeat (3) @(negedge clk);
        check("blinker_before_commit", cur_grid, 64'h1C0000);
        @(negedge clk);
        check("blinker_gen1", cur_grid, 64'h08080800);
        wait_halted(40);
        check("blinker_cause", 64'(halt_cause), 64'(OSC2));
        check("blinker_gen",   64'(gen_count), 64'd2);

        // Block: still life on one step
        load_seed(64'h60600);
        check("load_clears_halt", 64'(halted), 64'd0);
        push(64'h60600, 16'd1, 1'b1, 2'(STILL));
        pulse(3);
        check("block_cause", 64'(halt_cause), 64'(STILL));

        // Single cell: extinct on one step
        load_seed(64'h1);
        push(64'h0, 16'd1, 1'b1, 2'(EXTINCT));
        pulse(3);
        check("single_cause", 64'(halt_cause), 64'(EXTINCT));

        // Glider: generation limit 3 halts with cause NONE
        load_seed(64'h0E080400);
        push(64'h0000_0004_0C0A_0000, 16'd1, 1'b0, 2'(NONE));
        push(64'h0000_000C_0A08_0000, 16'd2, 1'b0, 2'(NONE));
        push(64'h0000_000C_1804_0000, 16'd3, 1'b1, 2'(NONE));
        pulse(1);
        wait_halted(60);
        check("glider_cause", 64'(halt_cause), 64'(NONE));
        check("glider_gen",   64'(gen_count), 64'd3);

        // Step during RUN ignored, then pause freezes the grid
        load_seed(64'h0E080400);
        pulse(1);
        pulse(3);
        check("run_step_grid", cur_grid, 64'h0E080400);
        pulse(2);
        check("pause_running", 64'(running), 64'd0);
        repeat (20) @(negedge clk);
        check("pause_grid", cur_grid, 64'h0E080400);
        check("pause_gen",  64'(gen_count), 64'd0);

        // load and run together: load wins, stays paused
        seed = 64'h60600;
        @(negedge clk);
        cmd_load = 1'b1; cmd_run = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0; cmd_run = 1'b0;
        check("loadrun_running", 64'(running), 64'd0);
        check("loadrun_grid", cur_grid, 64'h60600);

        // Reset at tick==2 in RUN
        load_seed(64'h0E080400);
        pulse(1);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_grid",  cur_grid, 64'd0);
        check("midrst_gen",   64'(gen_count), 64'd0);
        check("midrst_flags", 64'({evolve, running, halted}), 64'd0);
        check("midrst_cause", 64'(halt_cause), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        pulse(1);
        repeat (10) @(negedge clk);
        check("idle_run_running", 64'(running), 64'd0);
        check("idle_run_gen",     64'(gen_count), 64'd0);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
